// File: rtl/recv_window_capture.sv
// Shot-triggered receive window capture: waits a programmable delay, arms for the
// laser, then shifts NUM_SAMPLES receiver slices into a frame held until accepted.
module recv_window_capture #(
  parameter int RX_W          = 16,
  parameter int SAMPLE_W      = 8,
  parameter int SAMPLE_LSB    = 0,
  parameter int NUM_SAMPLES   = 50,
  parameter int DELAY_W       = 8,
  parameter int LASER_TIMEOUT = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            send_en,
  input  logic                            laser_enable,
  input  logic [RX_W-1:0]                 rx_dataout,
  input  logic [DELAY_W-1:0]              delay_cnt,
  input  logic                            frame_ready,
  output logic [SAMPLE_W*NUM_SAMPLES-1:0] frame_data,
  output logic                            frame_valid,
  output logic                            no_laser,
  output logic                            busy,
  output logic [15:0]                     overrun_cnt,
  output logic [2:0]                      dbg_state
);

  localparam int FRAME_W = SAMPLE_W * NUM_SAMPLES;
  localparam int ARM_W   = $clog2(LASER_TIMEOUT + 1);
  localparam int IDX_W   = $clog2(NUM_SAMPLES + 1);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(LASER_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SAMPLES - 1);

  if (SAMPLE_LSB + SAMPLE_W > RX_W) begin : g_bad_slice
    $error("recv_window_capture: sample slice exceeds rx_dataout width");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DELAY   = 3'd1,
    S_ARM     = 3'd2,
    S_CAPTURE = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [DELAY_W-1:0]   dly_target;
  logic [DELAY_W-1:0]   dly_cnt;
  logic [ARM_W-1:0]     arm_cnt;
  logic [IDX_W-1:0]     idx;
  logic [FRAME_W-1:0]   shift_reg;
  logic [FRAME_W-1:0]   shift_nxt;
  logic [SAMPLE_W-1:0]  sample;
  logic                 arm_timeout;
  logic                 last_sample;
  logic                 unused_rx;

  assign sample    = rx_dataout[SAMPLE_LSB +: SAMPLE_W];
  assign unused_rx = ^rx_dataout;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  // Newest sample enters at the top so sample 0 ends up in the lowest slice.
  if (NUM_SAMPLES == 1) begin : g_one
    assign shift_nxt = sample;
  end else begin : g_many
    assign shift_nxt = {sample, shift_reg[FRAME_W-1:SAMPLE_W]};
  end

  always_comb begin
    state_nxt   = state;
    arm_timeout = 1'b0;
    last_sample = 1'b0;
    case (state)
      S_IDLE:    if (send_en) state_nxt = S_DELAY;
      S_DELAY:   if (dly_cnt == dly_target) state_nxt = S_ARM;
      S_ARM: begin
        // A laser seen in the final allowed cycle beats the timeout.
        if (laser_enable) begin
          state_nxt = S_CAPTURE;
        end else if (arm_cnt == ARM_LAST) begin
          state_nxt   = S_IDLE;
          arm_timeout = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (idx == IDX_LAST) begin
          state_nxt   = S_HOLD;
          last_sample = 1'b1;
        end
      end
      S_HOLD:    if (frame_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      dly_target  <= '0;
      dly_cnt     <= '0;
      arm_cnt     <= '0;
      idx         <= '0;
      shift_reg   <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      no_laser    <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      state    <= state_nxt;
      no_laser <= arm_timeout;
      if (send_en && (state != S_IDLE) && (overrun_cnt != 16'hFFFF))
        overrun_cnt <= overrun_cnt + 16'd1;
      case (state)
        S_IDLE: begin
          if (send_en) begin
            dly_target <= delay_cnt;
            dly_cnt    <= '0;
          end
        end
        S_DELAY: begin
          if (dly_cnt != dly_target) dly_cnt <= dly_cnt + DELAY_W'(1);
          arm_cnt <= '0;
        end
        S_ARM: begin
          arm_cnt <= arm_cnt + ARM_W'(1);
          idx     <= '0;
        end
        S_CAPTURE: begin
          shift_reg <= shift_nxt;
          idx       <= idx + IDX_W'(1);
          if (last_sample) begin
            frame_data  <= shift_nxt;
            frame_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (frame_ready) frame_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_recv_window_capture.sv
// Directed bench for recv_window_capture: a per-cycle vector table for a full shot
// plus hand-written sequences for timeout, reset abort, saturation and slice offset.
module tb_recv_window_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        send_en, laser_enable, frame_ready;
  logic [15:0] rx_dataout;
  logic [7:0]  delay_cnt;
  logic [31:0] frame_data;
  logic        frame_valid, no_laser, busy;
  logic [15:0] overrun_cnt;
  logic [2:0]  dbg_state;

  logic        send_en2, frame_ready2;
  logic [15:0] frame_data2;
  logic        frame_valid2, no_laser2, busy2;
  logic [15:0] overrun_cnt2;
  logic [2:0]  dbg_state2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  recv_window_capture #(
    .RX_W(16), .SAMPLE_W(8), .SAMPLE_LSB(0), .NUM_SAMPLES(4),
    .DELAY_W(8), .LASER_TIMEOUT(3)
  ) u_dut (
    .clk(clk), .rst(rst), .send_en(send_en), .laser_enable(laser_enable),
    .rx_dataout(rx_dataout), .delay_cnt(delay_cnt), .frame_ready(frame_ready),
    .frame_data(frame_data), .frame_valid(frame_valid), .no_laser(no_laser),
    .busy(busy), .overrun_cnt(overrun_cnt), .dbg_state(dbg_state)
  );

  recv_window_capture #(
    .RX_W(16), .SAMPLE_W(8), .SAMPLE_LSB(8), .NUM_SAMPLES(2),
    .DELAY_W(8), .LASER_TIMEOUT(255)
  ) u_dut2 (
    .clk(clk), .rst(rst), .send_en(send_en2), .laser_enable(1'b1),
    .rx_dataout(16'hAB00), .delay_cnt(8'd0), .frame_ready(frame_ready2),
    .frame_data(frame_data2), .frame_valid(frame_valid2), .no_laser(no_laser2),
    .busy(busy2), .overrun_cnt(overrun_cnt2), .dbg_state(dbg_state2)
  );

  typedef struct {
    logic        send;
    logic        laser;
    logic [15:0] rx;
    logic        ready;
    logic [7:0]  dly;
    logic        exp_valid;
    logic        exp_busy;
    logic        exp_nol;
    logic [31:0] exp_data;
    logic [15:0] exp_ovr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic l, logic [15:0] r, logic rd, logic [7:0] d,
                              logic ev, logic eb, logic en, logic [31:0] ed, logic [15:0] eo);
    vec_t v;
    v.send = s; v.laser = l; v.rx = r; v.ready = rd; v.dly = d;
    v.exp_valid = ev; v.exp_busy = eb; v.exp_nol = en; v.exp_data = ed; v.exp_ovr = eo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Advance to the next cycle; outputs are then stable and inputs may be changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; send_en = 1'b0; laser_enable = 1'b0; frame_ready = 1'b0;
    rx_dataout = '0; delay_cnt = '0; send_en2 = 1'b0; frame_ready2 = 1'b0;

    // Shot D=2, N=4; delay_cnt changes mid-shot; overrun triggers at 3, 9, HOLD accept 15.
    vecs.push_back(mk(1,1,16'h0000,0,8'd2, 0,0,0,32'h0,        16'd0)); // 0
    vecs.push_back(mk(0,1,16'h0000,0,8'd7, 0,1,0,32'h0,        16'd0)); // 1
    vecs.push_back(mk(0,1,16'h0000,0,8'd7, 0,1,0,32'h0,        16'd0)); // 2
    vecs.push_back(mk(1,1,16'h0000,0,8'd7, 0,1,0,32'h0,        16'd0)); // 3
    vecs.push_back(mk(0,1,16'h0055,0,8'd7, 0,1,0,32'h0,        16'd1)); // 4 ARM
    vecs.push_back(mk(0,1,16'hFF11,0,8'd7, 0,1,0,32'h0,        16'd1)); // 5
    vecs.push_back(mk(0,0,16'hEE22,0,8'd7, 0,1,0,32'h0,        16'd1)); // 6
    vecs.push_back(mk(0,1,16'hDD33,0,8'd7, 0,1,0,32'h0,        16'd1)); // 7
    vecs.push_back(mk(0,0,16'hCC44,0,8'd7, 0,1,0,32'h0,        16'd1)); // 8
    vecs.push_back(mk(1,0,16'h0066,0,8'd7, 1,1,0,32'h44332211, 16'd1)); // 9
    vecs.push_back(mk(0,0,16'h0077,0,8'd7, 1,1,0,32'h44332211, 16'd2)); // 10
    vecs.push_back(mk(0,0,16'h0000,0,8'd7, 1,1,0,32'h44332211, 16'd2)); // 11
    vecs.push_back(mk(0,0,16'h0000,0,8'd7, 1,1,0,32'h44332211, 16'd2)); // 12
    vecs.push_back(mk(0,0,16'h0000,0,8'd7, 1,1,0,32'h44332211, 16'd2)); // 13
    vecs.push_back(mk(0,0,16'h0000,0,8'd7, 1,1,0,32'h44332211, 16'd2)); // 14
    vecs.push_back(mk(1,0,16'h0000,1,8'd7, 1,1,0,32'h44332211, 16'd2)); // 15 accept
    vecs.push_back(mk(0,0,16'h0000,0,8'd7, 0,0,0,32'h44332211, 16'd3)); // 16
    vecs.push_back(mk(0,0,16'h0000,0,8'd7, 0,0,0,32'h44332211, 16'd3)); // 17

    repeat (3) tick();
    chk("rst_valid", frame_valid, 0);
    chk("rst_data",  frame_data, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_nol",   no_laser, 0);
    chk("rst_ovr",   overrun_cnt, 0);
    chk("rst_valid2", frame_valid2, 0);
    rst = 1'b1;
    tick();

    foreach (vecs[i]) begin
      tick();
      chk($sformatf("tbl%0d_valid", i), frame_valid, vecs[i].exp_valid);
      chk($sformatf("tbl%0d_busy", i),  busy,        vecs[i].exp_busy);
      chk($sformatf("tbl%0d_nol", i),   no_laser,    vecs[i].exp_nol);
      chk($sformatf("tbl%0d_data", i),  frame_data,  vecs[i].exp_data);
      chk($sformatf("tbl%0d_ovr", i),   overrun_cnt, vecs[i].exp_ovr);
      send_en = vecs[i].send; laser_enable = vecs[i].laser; rx_dataout = vecs[i].rx;
      frame_ready = vecs[i].ready; delay_cnt = vecs[i].dly;
    end

    // ARM timeout: D=0, no laser -> ARM 2..4, no_laser pulse at 5, frame untouched.
    tick();
    send_en = 1'b1; delay_cnt = 8'd0; laser_enable = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      send_en = 1'b0;
      chk($sformatf("to%0d_busy", c),  busy, (c <= 4));
      chk($sformatf("to%0d_nol", c),   no_laser, (c == 5));
      chk($sformatf("to%0d_valid", c), frame_valid, 0);
      chk($sformatf("to%0d_data", c),  frame_data, 32'h44332211);
    end

    // Laser only in the last allowed ARM cycle wins; laser ignored while capturing.
    tick();
    send_en = 1'b1; delay_cnt = 8'd0; laser_enable = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      send_en = 1'b0;
      chk($sformatf("lw%0d_nol", c),   no_laser, 0);
      chk($sformatf("lw%0d_valid", c), frame_valid, (c == 9));
      chk($sformatf("lw%0d_busy", c),  busy, (c <= 9));
      if (c == 9) chk("lw_data", frame_data, 32'hA8A7A6A5);
      laser_enable = (c == 4);
      rx_dataout   = {8'h5A, 8'hA0 + 8'(c)};
      frame_ready  = (c == 9);
    end
    frame_ready = 1'b0;

    // Reset at cycle 7 of a shot aborts it; a fresh trigger at 10 gives a frame at 19.
    tick();
    send_en = 1'b1; delay_cnt = 8'd2; laser_enable = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c >= 8) begin
        chk($sformatf("ra%0d_valid", c), frame_valid, (c == 19));
        chk($sformatf("ra%0d_busy", c),  busy, (c >= 11 && c <= 19));
        chk($sformatf("ra%0d_nol", c),   no_laser, 0);
        if (c <= 9) begin
          chk($sformatf("ra%0d_data", c), frame_data, 0);
          chk($sformatf("ra%0d_ovr", c),  overrun_cnt, 0);
        end
      end
      if (c == 19) chk("ra_data", frame_data, 32'h04030201);
      send_en     = (c == 10);
      rst         = (c != 7);
      rx_dataout  = (c >= 15 && c <= 18) ? 16'(c - 14) : 16'h00EE;
      frame_ready = (c == 19);
    end
    frame_ready = 1'b0;
    chk("ra_end_valid", frame_valid, 0);

    // Held send_en: one shot reaches HOLD, every later cycle counts, saturating.
    tick();
    send_en = 1'b1; delay_cnt = 8'd0; laser_enable = 1'b1;
    for (int c = 1; c <= 66000; c++) begin
      tick();
      if (c == 1001) chk("sat_mid", overrun_cnt, 16'd1000);
    end
    chk("sat_ovr", overrun_cnt, 16'hFFFF);
    chk("sat_valid", frame_valid, 1);
    send_en = 1'b0; frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("sat_done_valid", frame_valid, 0);
    chk("sat_hold_ovr", overrun_cnt, 16'hFFFF);

    // Offset slice: SAMPLE_LSB=8, N=2, D=0 -> frame 0xABAB at cycle 5.
    tick();
    send_en2 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      send_en2 = 1'b0;
      chk($sformatf("sl%0d_valid", c), frame_valid2, (c >= 5));
      if (c == 5) chk("sl_data", frame_data2, 16'hABAB);
    end
    frame_ready2 = 1'b1;
    tick();
    chk("sl_accept_valid", frame_valid2, 0);
    chk("sl_accept_busy", busy2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/recv_window_capture.md
RECV_WINDOW_CAPTURE -- requirements
Module: recv_window_capture

Interface
REQ-001 Parameter RX_W, default 16, SHALL set the width of the rx_dataout bus.
REQ-002 Parameter SAMPLE_W, default 8, SHALL set the bits kept per sample.
REQ-003 Parameter SAMPLE_LSB, default 0, SHALL select the sample slice rx_dataout[SAMPLE_LSB+SAMPLE_W-1:SAMPLE_LSB]; elaboration SHALL fail if SAMPLE_LSB+SAMPLE_W > RX_W.
REQ-004 Parameter NUM_SAMPLES, default 50, SHALL set the samples per frame; the value is >= 1.
REQ-005 Parameter DELAY_W, default 8, SHALL set the width of delay_cnt.
REQ-006 Parameter LASER_TIMEOUT, default 255, SHALL set the maximum ARM dwell in cycles; the value is >= 1.
REQ-007 clk  in  1  SHALL be the single clock; all logic is on the rising edge.
REQ-008 rst  in  1  SHALL be a synchronous, active-low reset.
REQ-009 send_en  in  1  SHALL be the shot trigger, sampled each cycle.
REQ-010 laser_enable  in  1  SHALL indicate that the laser actually fired.
REQ-011 rx_dataout  in  RX_W  SHALL be the receiver sample stream.
REQ-012 delay_cnt  in  DELAY_W  SHALL be the send-to-arm delay, latched on trigger acceptance.
REQ-013 frame_ready  in  1  SHALL be the consumer accept input.
REQ-014 frame_data  out  SAMPLE_W*NUM_SAMPLES  SHALL carry the captured frame, with sample 0 in the lowest slice.
REQ-015 frame_valid  out  1  SHALL mark frame_data as valid.
REQ-016 no_laser  out  1  SHALL pulse for one cycle on an ARM timeout.
REQ-017 busy  out  1  SHALL be 1 whenever the state is not IDLE.
REQ-018 overrun_cnt  out  16  SHALL count ignored triggers and saturate at 0xFFFF.

Function
REQ-019 The FSM SHALL have the states IDLE, DELAY, ARM, CAPTURE and HOLD.
REQ-020 IDLE: if send_en=1 in cycle T, the FSM SHALL latch delay_cnt as D, clear the delay counter, and be in DELAY at T+1.
REQ-021 DELAY: the counter SHALL increment while it is not equal to D; the FSM SHALL leave for ARM when it equals D, so DELAY lasts D+1 cycles (D=0 gives 1 cycle).
REQ-022 ARM: if laser_enable=1 in cycle A, the FSM SHALL enter CAPTURE at A+1 with the sample index at 0.
REQ-023 ARM: if laser_enable=0 for LASER_TIMEOUT consecutive ARM cycles, the next cycle SHALL have no_laser=1 and state IDLE, with frame_data and frame_valid unchanged.
REQ-024 ARM: laser_enable=1 in the last allowed ARM cycle SHALL win over the timeout.
REQ-025 CAPTURE: in each of cycles A+1..A+NUM_SAMPLES the selected slice SHALL shift in at the top of the shift register, with the older contents moving down by SAMPLE_W.
REQ-026 CAPTURE: laser_enable SHALL be ignored.
REQ-027 On the edge capturing the last sample, the block SHALL load frame_data with the full shift contents including that sample, set frame_valid to 1 at cycle A+NUM_SAMPLES+1, and enter HOLD.
REQ-028 HOLD: frame_valid and frame_data SHALL stay stable until a cycle with frame_ready=1; frame_valid SHALL be 0 and the state IDLE in the following cycle.
REQ-029 If frame_ready is already 1, frame_valid SHALL be high for exactly one cycle.
REQ-030 A send_en=1 in any state other than IDLE, including the HOLD accept cycle, SHALL be ignored and SHALL increment overrun_cnt, saturating at 0xFFFF.
REQ-031 A send_en held high SHALL count as one trigger per cycle, so retriggering from IDLE occurs at the first IDLE cycle in which send_en=1.
REQ-032 The latched D SHALL be unaffected by changes on delay_cnt during a shot.
REQ-033 End-to-end latency from trigger in cycle T, with laser_enable already high, SHALL be frame_valid at T+D+NUM_SAMPLES+3.

Reset
REQ-034 With rst=0 at a rising edge, the next state SHALL be IDLE, with frame_data=0, frame_valid=0, no_laser=0, busy=0, overrun_cnt=0, the shift register cleared and the counters cleared.
REQ-035 A reset during any state SHALL abort the shot and discard partial samples, with no frame_valid and no no_laser pulse.
REQ-036 Reset SHALL take priority over all other inputs in the same cycle.

Verification
REQ-037 N=4, W=8, D=2, laser_enable=1, send_en at cycle 0, rx_dataout[7:0]=0x11,0x22,0x33,0x44 in cycles 5..8 -> frame_valid=1 at cycle 9 with frame_data=0x44332211, busy=1 in cycles 1..9.
REQ-038 Same as REQ-037 with frame_ready=0 until cycle 15 -> frame_valid and data held through cycle 15, frame_valid=0 and busy=0 at cycle 16.
REQ-039 LASER_TIMEOUT=3, laser_enable=0, D=0 -> ARM in cycles 2..4, no_laser=1 at cycle 5 only, frame_valid stays 0, busy=0 at 5.
REQ-040 send_en pulses at cycles 3 and 9 during a shot, plus one in the HOLD accept cycle -> overrun_cnt=3 and only one frame produced; after 70000 ignored triggers, overrun_cnt=0xFFFF.
REQ-041 rst=0 at cycle 7 of REQ-037 -> all outputs 0 from cycle 8, no frame_valid; a new send_en at 10 yields a correct frame at 19.
REQ-042 SAMPLE_LSB=8, rx_dataout=0xAB00 constant, N=2 -> frame_data=0xABAB.
